// File: rtl/mips_pkg.sv
// Shared loader definitions: FSM state encoding, stream constants and image-size limit.
package mips_pkg;

  typedef enum logic [2:0] {StIdle, StData, StCheck, StDone, StErr} load_state_e;

  localparam int unsigned CountW       = 8;
  localparam int unsigned BytesPerWord = 4;

  // Number of 32-bit words addressable with an addr_w-bit byte address.
  function automatic int unsigned max_words(input int unsigned addr_w);
    return 32'd1 << (addr_w - 2);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Shifts stream bytes MSB-first into a 32-bit word and pulses word_valid_o on the 4th byte.
module word_packer
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[15:0], byte_i};
      idx_d   = idx_q + 2'd1;
    end
  end

  // The completed word includes the byte arriving this cycle.
  assign word_valid_o = byte_valid_i && !clear_i && (idx_q == 2'(BytesPerWord - 1));
  assign word_o       = {shift_q, byte_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: count byte, N big-endian words, optional XOR checksum.
// Define IMEM_LOADER_CHECKSUM_EN to expect and verify the trailing checksum byte.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              core_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned MaxWords = max_words(ADDR_W);
  localparam int unsigned IdxW     = ADDR_W - 2;

  load_state_e       state_q, state_d;
  logic              live_q;
  logic [CountW-1:0] n_q, n_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept, pack_valid, pack_clear, word_valid, last_word;
  logic [31:0] word;

  assign accept     = in_valid_i && in_ready_o;
  assign pack_valid = accept && (state_q == StData);
  assign pack_clear = start_i || (state_q != StData);
  assign last_word  = (32'(idx_q) == 32'(n_q) - 32'd1);

  word_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_valid),
    .byte_i       (in_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (start_i) begin
      state_d = StIdle;
      n_d     = '0;
      idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (in_data_i == '0 || 32'(in_data_i) > MaxWords) begin
              state_d = StErr;
            end else begin
              state_d = StData;
              n_d     = in_data_i;
              idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum_d  = '0;
`endif
            end
          end
        end
        StData: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ in_data_i;
`endif
            if (word_valid) begin
              idx_d = idx_q + IdxW'(1);
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = StCheck;
`else
                state_d = StDone;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) begin
            state_d = (in_data_i == csum_q) ? StDone : StErr;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      live_q  <= 1'b0;
      n_q     <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      live_q <= 1'b1;
      n_q    <= n_d;
      idx_q  <= idx_d;
      we_q   <= word_valid;
      if (word_valid) begin
        addr_q  <= {idx_q, 2'b00};
        wdata_q <= word;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end

  // Release is masked while the last write is still on the bus.
  always_comb begin
    in_ready_o  = live_q && !start_i &&
                  (state_q == StIdle || state_q == StData || state_q == StCheck);
    done_o      = (state_q == StDone) && !we_q;
    err_o       = (state_q == StErr);
    core_hold_o = !done_o;
  end

  assign im_we_o    = we_q;
  assign im_addr_o  = addr_q;
  assign im_wdata_o = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level image model.
// Honours IMEM_LOADER_CHECKSUM_EN to append and verify the checksum byte.
module tb_imem_loader;

  localparam int unsigned AddrW    = 8;
  localparam int unsigned MaxWords = 1 << (AddrW - 2);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             im_we;
  logic [AddrW-1:0] im_addr;
  logic [31:0]      im_wdata;
  logic             core_hold;
  logic             done;
  logic             err;

  int total = 0;
  int bad   = 0;

  imem_loader #(.ADDR_W(AddrW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .im_we_o     (im_we),
    .im_addr_o   (im_addr),
    .im_wdata_o  (im_wdata),
    .core_hold_o (core_hold),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Write log captured just after each rising edge.
  int          cyc = 0;
  int          done_cyc = -1;
  bit          done_prev = 1'b0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] img[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (im_we) begin
        wr_addr.push_back(32'(im_addr));
        wr_data.push_back(im_wdata);
        wr_cyc.push_back(cyc);
      end
      if (done && !done_prev) done_cyc = cyc;
      done_prev = done;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc = -1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ready"}, 32'(in_ready), 0);
    check_val({tag, "_we"}, 32'(im_we), 0);
    check_val({tag, "_addr"}, 32'(im_addr), 0);
    check_val({tag, "_wdata"}, im_wdata, 0);
    check_val({tag, "_hold"}, 32'(core_hold), 1);
    check_val({tag, "_done"}, 32'(done), 0);
    check_val({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_ready"}, 32'(in_ready), 1);
    check_val({tag, "_done"}, 32'(done), 0);
    check_val({tag, "_err"}, 32'(err), 0);
    check_val({tag, "_hold"}, 32'(core_hold), 1);
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready) check_val("ready_timeout", 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_idle("start");
  endtask

  // Streams img as one load and checks the image, verdict and timing.
  task automatic run_load(input bit gaps, input bit bad_csum);
    logic [7:0] csum;
    logic [7:0] b;
    int         n;
    bit         exp_err;
    n       = img.size();
    csum    = 8'h00;
    exp_err = 1'b0;
    clear_log();
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        if (gaps) idle($urandom_range(0, 2));
        b    = img[i][8*k +: 8];
        csum = csum ^ b;
        send_byte(b);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (gaps) idle($urandom_range(0, 2));
    exp_err = bad_csum;
    send_byte(bad_csum ? ((csum == 8'h00) ? 8'hFF : 8'h00) : csum);
    check_val("verdict_done", 32'(done), 32'(!exp_err));
    check_val("verdict_err", 32'(err), 32'(exp_err));
`else
    if (bad_csum) exp_err = 1'b0;
    check_val("early_done", 32'(done), 0);
`endif
    idle(2);
    check_val("nwrites", wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check_val($sformatf("addr%0d", i), wr_addr[i], 32'(i * 4));
      check_val($sformatf("data%0d", i), wr_data[i], img[i]);
      if (!gaps && i > 0) check_val($sformatf("spacing%0d", i), wr_cyc[i] - wr_cyc[i-1], 4);
    end
    check_val("done", 32'(done), 32'(!exp_err));
    check_val("err", 32'(err), 32'(exp_err));
    check_val("hold", 32'(core_hold), 32'(exp_err));
    check_val("ready_after", 32'(in_ready), 0);
    if (!exp_err && wr_cyc.size() > 0) begin
      check_val("done_after_we", 32'(done_cyc > wr_cyc[wr_cyc.size()-1]), 1);
      if (!gaps) check_val("done_lat", done_cyc - wr_cyc[wr_cyc.size()-1], 1);
    end
    // Trailing bytes must be ignored.
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    idle(3);
    in_valid = 1'b0;
    #1;
    check_val("extra_nwrites", wr_addr.size(), n);
    check_val("extra_done", 32'(done), 32'(!exp_err));
  endtask

  task automatic bad_count(input logic [7:0] cnt);
    clear_log();
    send_byte(cnt);
    check_val("cnt_err", 32'(err), 1);
    check_val("cnt_hold", 32'(core_hold), 1);
    check_val("cnt_ready", 32'(in_ready), 0);
    idle(2);
    check_val("cnt_nwrites", wr_addr.size(), 0);
    pulse_start();
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle(3);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    #1;
    check_val("ready_pre", 32'(in_ready), 0);
    @(negedge clk);
    #1;
    check_val("ready_post", 32'(in_ready), 1);

    img = '{32'h20080005};
    run_load(1'b0, 1'b0);
    pulse_start();
    img = '{32'h20080005, 32'h01084020};
    run_load(1'b0, 1'b0);
    pulse_start();
`ifdef IMEM_LOADER_CHECKSUM_EN
    img = '{32'h20080005};
    run_load(1'b0, 1'b1);
    pulse_start();
`endif

    bad_count(8'h00);
    bad_count(8'(MaxWords + 1));
    bad_count(8'($urandom_range(MaxWords + 1, 255)));

    // start collides with a presented byte mid-word.
    clear_log();
    send_byte(8'h02);
    send_byte(8'hAA);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    #1;
    check_val("start_ready", 32'(in_ready), 0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_idle("abort");
    check_val("abort_nwrites", wr_addr.size(), 0);
    img = '{32'h20080005};
    run_load(1'b0, 1'b0);
    pulse_start();

    // Reset in the middle of DATA after one word has been written.
    rand_img(3);
    send_byte(8'h03);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(1, 255)));
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_vals("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    rand_img($urandom_range(1, 8));
    run_load(1'b0, 1'b0);
    pulse_start();

    for (int t = 0; t < 6; t++) begin
      rand_img((t == 0) ? MaxWords : $urandom_range(1, MaxWords));
      run_load(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      pulse_start();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
